// File: rtl/fetch_decode_queue.sv
// Fetch-to-Decode instruction buffer.
// Holds fetched {instr, pc, pc8} entries in a small circular FIFO and presents
// the oldest one to Decode under a valid/ready handshake. in_ready feeds the
// Fetch PC-register enable, so a full queue stalls the PC. flush discards all
// wrong-path entries after a taken branch or a PC write.
module fetch_decode_queue #(
  parameter int IW    = 32,
  parameter int AW    = 18,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,        // asynchronous, active low
  input  logic                       in_valid,
  input  logic [IW-1:0]              in_instr,
  input  logic [AW-1:0]              in_pc,
  input  logic [AW-1:0]              in_pc8,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [IW-1:0]              out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [AW-1:0]              out_pc8,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // The three fields of an entry are stored as one word so they can never
  // drift apart.
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc8;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted, non-flushed push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy is tracked by the
    // pointers and count, and stale contents are never presented.
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, pc8: in_pc8};
    end
  end

  // Head entry read combinationally; driven to zero while empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_pc8   = head.pc8;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int IW    = 32;
  localparam int AW    = 18;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc8;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic [AW-1:0] in_pc8;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc8;
  logic          out_ready;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t model_q[$];

  fetch_decode_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_pc8    (in_pc8),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc8   (out_pc8),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output with what the model's contents imply.
  task automatic check_outputs(input string tag);
    ent_t h;
    h = (model_q.size() != 0) ? model_q[0] : '0;
    check({tag, "_count"},     64'(count),     64'(model_q.size()));
    check({tag, "_in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({tag, "_out_instr"}, 64'(out_instr), 64'(h.instr));
    check({tag, "_out_pc"},    64'(out_pc),    64'(h.pc));
    check({tag, "_out_pc8"},   64'(out_pc8),   64'(h.pc8));
  endtask

  // One clock cycle: called just after a falling edge, returns after the next.
  task automatic step(input string tag, input logic v, input logic [IW-1:0] ins,
                      input logic [AW-1:0] pc, input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_pc8    = pc + AW'(8);
    out_ready = rdy;
    flush     = fl;
    #1 check_outputs(tag);
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = rdy && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: ins, pc: pc, pc8: pc + AW'(8)});
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pc8 = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state.
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single push, visible after one edge.
    step("tp1", 1'b1, 32'hE3A01005, 18'h0, 1'b0, 1'b0);
    check("tp1_instr", 64'(out_instr), 64'hE3A01005);
    check("tp1_pc8", 64'(out_pc8), 64'd8);
    check("tp1_count", 64'(count), 64'd1);
    step("tp1_drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Fill to full, fifth push ignored, then drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'h1000 + i, AW'(4 * i), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step("fifth", 1'b1, 32'hDEAD, 18'h10, 1'b0, 1'b0);
    check("fifth_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(out_pc), 64'(4 * i));
      step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    end
    check("drained_in_ready", 64'(in_ready), 64'd1);

    // Steady push+pop at count=2, pointers wrap.
    step("c2a", 1'b1, 32'hA0, 18'h08, 1'b0, 1'b0);
    step("c2b", 1'b1, 32'hA1, 18'h0C, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("pp", 1'b1, 32'hB0 + i, AW'(18'h10 + 4 * i), 1'b1, 1'b0);
      check("pp_count", 64'(count), 64'd2);
    end
    check("pp_head", 64'(out_pc), 64'h20);

    // Flush at count=3 with simultaneous push and pop.
    step("c3", 1'b1, 32'hC0, 18'h28, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd3);
    step("flush", 1'b1, 32'hC1, 18'h30, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step("post_flush", 1'b1, 32'hC2, 18'h100, 1'b0, 1'b0);
    check("post_flush_pc", 64'(out_pc), 64'h100);

    // Asynchronous reset while full.
    for (int i = 0; i < 3; i++) step("fill2", 1'b1, 32'hD0 + i, AW'(18'h200 + 4 * i), 1'b0, 1'b0);
    check("fill2_count", 64'(count), 64'd4);
    #2 rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step("post_arst", 1'b1, 32'hE0, 18'h40, 1'b0, 1'b0);
    check("post_arst_pc", 64'(out_pc), 64'h40);
    step("post_arst_drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Empty queue with out_ready held: no underflow.
    for (int i = 0; i < 3; i++) step("empty_pop", 1'b0, '0, '0, 1'b1, 1'b0);
    check("empty_count", 64'(count), 64'd0);
    check("empty_out_instr", 64'(out_instr), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, AW'($urandom),
           1'($urandom_range(0, 2) == 0 ? 0 : 1), 1'($urandom_range(0, 24) == 0));
    end
    idle("final");
    #1 check_outputs("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
